hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter XLEN, default 64, PC/target width.
REQ-002 SHALL provide parameter RA_W, default 5, register-address width.
REQ-003 SHALL provide parameter MD_MAX, default 64, multi-cycle-op watchdog limit in cycles (>=2).
REQ-004 SHALL provide ports clk in 1 (only clock); rst in 1 (synchronous, active-high).
REQ-005 SHALL provide rs1_IDR, rs2_IDR in RA_W (sources in IDR); rs1_used_IDR, rs2_used_IDR in 1 (source valid).
REQ-006 SHALL provide rd_EXA in RA_W and mem_read_EXA in 1 (load occupying EXA).
REQ-007 SHALL provide md_req_EXA in 1 (mul/div enters EXA) and md_done in 1 (mul/div result ready).
REQ-008 SHALL provide branch_taken_EXB in 1 and branch_target_EXB in XLEN (resolved redirect).
REQ-009 SHALL provide stall_IFP, stall_IFR, stall_IDC, stall_IDR, stall_EXA out 1 (hold stage register).
REQ-010 SHALL provide bubble_EXA out 1 (insert NOP into EXA), plus flush_IFR, flush_IDC, flush_IDR, flush_EXA out 1.
REQ-011 SHALL provide redirect_valid_IFP out 1, redirect_pc_IFP out XLEN, and md_timeout out 1.

Function
REQ-012 Flush: branch_taken_EXB high in cycle N SHALL assert all four flush_* combinationally in N.
REQ-013 Redirect: redirect_valid_IFP SHALL be a registered copy of branch_taken_EXB, high only in N+1, with redirect_pc_IFP = target captured in N; flush_IFR SHALL also be high in N+1.
REQ-014 Load-use: mem_read_EXA && rd_EXA!=0 && ((rs1_used_IDR && rs1_IDR==rd_EXA) || (rs2_used_IDR && rs2_IDR==rd_EXA)) SHALL assert stall_IFP..stall_IDR and bubble_EXA for that cycle only (combinational).
REQ-015 FSM states RUN, MD_WAIT: RUN->MD_WAIT on md_req_EXA && !branch_taken_EXB && !md_done; otherwise hold RUN.
REQ-016 In MD_WAIT, stall_IFP..stall_EXA SHALL be high except in a cycle where md_done, branch_taken_EXB, or timeout holds; any of these returns the FSM to RUN next cycle.
REQ-017 md_req_EXA && md_done in the same RUN cycle SHALL not stall and SHALL stay in RUN.
REQ-018 A 16-bit cycle counter SHALL clear on MD_WAIT entry and increment each MD_WAIT cycle; counter==MD_MAX-1 SHALL pulse md_timeout for one cycle and release stalls.
REQ-019 Priority SHALL be branch flush > MD stall > load-use; a branch suppresses all stall_* and bubble_EXA in that cycle.
REQ-020 Load-use detection SHALL be masked while in MD_WAIT (front end already held).

Reset
REQ-021 rst SHALL force FSM=RUN, counter=0, redirect_valid_IFP=0, redirect_pc_IFP=0, md_timeout=0, counters=0; all combinational outputs SHALL be 0 during reset.
REQ-022 Reset asserted in MD_WAIT SHALL abandon the wait with no timeout pulse.

Configuration
REQ-023 Macro HAZARD_PERF_EN defined SHALL add outputs perf_stall_cnt and perf_flush_cnt (32 bits each) counting cycles with any stall_* high and cycles with branch_taken_EXB high, wrapping at 2^32.
REQ-024 Without HAZARD_PERF_EN, those ports and registers SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-025 Package hazard_pkg SHALL hold the FSM state enum (RUN, MD_WAIT) and the counter width constant.
REQ-026 The MD FSM plus watchdog SHALL be a sub-module hazard_md_fsm; load-use and flush logic SHALL stay in the top level.

Verification
REQ-027 Load x5 in EXA, IDR uses rs1=x5 -> one-cycle stall_IFP..stall_IDR + bubble_EXA; rd_EXA=0 -> no stall.
REQ-028 branch_taken_EXB=1, target 0x8000_0040 in N -> flush_* in N; redirect_valid_IFP=1, pc=0x8000_0040, flush_IFR=1 in N+1 only.
REQ-029 md_req_EXA, md_done after 5 cycles -> stall_IFP..stall_EXA high exactly 5 cycles, then RUN.
REQ-030 md_req_EXA, no md_done, MD_MAX=8 -> md_timeout single pulse in 8th MD_WAIT cycle, stalls released.
REQ-031 Branch in MD_WAIT cycle 3 plus simultaneous load-use match -> flushes only, no stalls, RUN next cycle; rst mid-MD_WAIT -> RUN, no timeout.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: FSM state enum and watchdog counter width shared by hazard_ctrl and its sub-module
package hazard_pkg;
  typedef enum logic {RUN, MD_WAIT} md_state_e;
  localparam int CNT_W = 16;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard unit bundle; perf counter signals exist only with HAZARD_PERF_EN
interface hazard_ctrl_if #(parameter int XLEN = 64, parameter int RA_W = 5);
  logic [RA_W-1:0] rs1_IDR, rs2_IDR, rd_EXA;
  logic            rs1_used_IDR, rs2_used_IDR, mem_read_EXA;
  logic            md_req_EXA, md_done, branch_taken_EXB;
  logic [XLEN-1:0] branch_target_EXB, redirect_pc_IFP;
  logic            stall_IFP, stall_IFR, stall_IDC, stall_IDR, stall_EXA, bubble_EXA;
  logic            flush_IFR, flush_IDC, flush_IDR, flush_EXA;
  logic            redirect_valid_IFP, md_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0]     perf_stall_cnt, perf_flush_cnt;
  modport master (
    output rs1_IDR, rs2_IDR, rs1_used_IDR, rs2_used_IDR, rd_EXA, mem_read_EXA,
           md_req_EXA, md_done, branch_taken_EXB, branch_target_EXB,
    input  stall_IFP, stall_IFR, stall_IDC, stall_IDR, stall_EXA, bubble_EXA,
           flush_IFR, flush_IDC, flush_IDR, flush_EXA, redirect_valid_IFP, redirect_pc_IFP,
           md_timeout, perf_stall_cnt, perf_flush_cnt
  );
  modport slave (
    input  rs1_IDR, rs2_IDR, rs1_used_IDR, rs2_used_IDR, rd_EXA, mem_read_EXA,
           md_req_EXA, md_done, branch_taken_EXB, branch_target_EXB,
    output stall_IFP, stall_IFR, stall_IDC, stall_IDR, stall_EXA, bubble_EXA,
           flush_IFR, flush_IDC, flush_IDR, flush_EXA, redirect_valid_IFP, redirect_pc_IFP,
           md_timeout, perf_stall_cnt, perf_flush_cnt
  );
`else
  modport master (
    output rs1_IDR, rs2_IDR, rs1_used_IDR, rs2_used_IDR, rd_EXA, mem_read_EXA,
           md_req_EXA, md_done, branch_taken_EXB, branch_target_EXB,
    input  stall_IFP, stall_IFR, stall_IDC, stall_IDR, stall_EXA, bubble_EXA,
           flush_IFR, flush_IDC, flush_IDR, flush_EXA, redirect_valid_IFP, redirect_pc_IFP,
           md_timeout
  );
  modport slave (
    input  rs1_IDR, rs2_IDR, rs1_used_IDR, rs2_used_IDR, rd_EXA, mem_read_EXA,
           md_req_EXA, md_done, branch_taken_EXB, branch_target_EXB,
    output stall_IFP, stall_IFR, stall_IDC, stall_IDR, stall_EXA, bubble_EXA,
           flush_IFR, flush_IDC, flush_IDR, flush_EXA, redirect_valid_IFP, redirect_pc_IFP,
           md_timeout
  );
`endif
endinterface

// File: rtl/hazard_md_fsm.sv
// hazard_md_fsm: multi-cycle op wait FSM with watchdog that releases the pipeline after MD_MAX cycles
module hazard_md_fsm
  import hazard_pkg::*;
#(
  parameter int MD_MAX = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic md_req_i,
  input  logic md_done_i,
  input  logic branch_i,
  output logic md_wait_o,
  output logic md_stall_o,
  output logic md_timeout_o
);
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_s, timeout_s, exit_s;
  always_comb begin
    wait_s    = !rst && state_q == MD_WAIT;
    timeout_s = wait_s && cnt_q == CNT_W'(MD_MAX - 1);
    exit_s    = md_done_i || branch_i || timeout_s;
    state_d   = wait_s ? (exit_s ? RUN : MD_WAIT)
                       : ((md_req_i && !branch_i && !md_done_i) ? MD_WAIT : RUN);
    cnt_d     = wait_s ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign md_wait_o    = wait_s;
  assign md_stall_o   = wait_s && !exit_s;
  assign md_timeout_o = timeout_s;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/redirect control; HAZARD_PERF_EN adds stall/flush cycle counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int RA_W   = 5,
  parameter int MD_MAX = 64
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);
  logic            br, lu, md_wait, md_stall, md_timeout, stall_fe;
  logic [RA_W-1:0] rd;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  hazard_md_fsm #(.MD_MAX(MD_MAX)) u_md (
    .clk         (clk),
    .rst         (rst),
    .md_req_i    (bus.md_req_EXA),
    .md_done_i   (bus.md_done),
    .branch_i    (br),
    .md_wait_o   (md_wait),
    .md_stall_o  (md_stall),
    .md_timeout_o(md_timeout)
  );
  // load-use is ignored in MD_WAIT since the front end is already held
  always_comb begin
    rd               = bus.rd_EXA;
    br               = !rst && bus.branch_taken_EXB;
    lu               = !rst && !md_wait && bus.mem_read_EXA && rd != '0 &&
                       ((bus.rs1_used_IDR && bus.rs1_IDR == rd) ||
                        (bus.rs2_used_IDR && bus.rs2_IDR == rd));
    stall_fe         = !br && (md_stall || lu);
    redirect_valid_d = br;
    redirect_pc_d    = br ? bus.branch_target_EXB : redirect_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end
  assign bus.stall_IFP          = stall_fe;
  assign bus.stall_IFR          = stall_fe;
  assign bus.stall_IDC          = stall_fe;
  assign bus.stall_IDR          = stall_fe;
  assign bus.stall_EXA          = !br && md_stall;
  assign bus.bubble_EXA         = !br && lu;
  assign bus.flush_IFR          = br || (!rst && redirect_valid_q);
  assign bus.flush_IDC          = br;
  assign bus.flush_IDR          = br;
  assign bus.flush_EXA          = br;
  assign bus.redirect_valid_IFP = redirect_valid_q;
  assign bus.redirect_pc_IFP    = redirect_pc_q;
  assign bus.md_timeout         = md_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;
  always_comb begin
    perf_stall_d = perf_stall_q + 32'(stall_fe);
    perf_flush_d = perf_flush_q + 32'(br);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end
  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with queued expectations checked by an independent monitor
module tb_hazard_ctrl;
  // flags = {stall IFP,IFR,IDC,IDR,EXA, bubble, flush IFR,IDC,IDR,EXA, redirect_valid, md_timeout}
  localparam logic [11:0] NONE = 12'h000, LU = 12'hF40, MDS = 12'hF80;
  localparam logic [11:0] BR = 12'h03C, RED = 12'h022, TO = 12'h001;
  localparam logic [63:0] Z = 64'h0, T1 = 64'h8000_0040, T2 = 64'h0000_1234, T3 = 64'h8000_0100;
  typedef struct {
    string       name;
    logic [11:0] f;
    logic [63:0] pc;
  } exp_t;
  exp_t q[$];
  int   vectors = 0, miscompares = 0;
  logic clk = 1'b0, rst = 1'b1;
  hazard_ctrl_if #(.XLEN(64), .RA_W(5)) bus ();
  hazard_ctrl #(.XLEN(64), .RA_W(5), .MD_MAX(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic cyc(input string name, input int r, input int rd, input int mr, input int rs1,
                     input int u1, input int rs2, input int u2, input int mdr, input int mdd,
                     input int bt, input logic [63:0] tgt, input logic [11:0] ef,
                     input logic [63:0] epc);
    exp_t e;
    @(posedge clk);
    #1;
    rst                   = (r != 0);
    bus.rd_EXA            = 5'(rd);
    bus.mem_read_EXA      = (mr != 0);
    bus.rs1_IDR           = 5'(rs1);
    bus.rs1_used_IDR      = (u1 != 0);
    bus.rs2_IDR           = 5'(rs2);
    bus.rs2_used_IDR      = (u2 != 0);
    bus.md_req_EXA        = (mdr != 0);
    bus.md_done           = (mdd != 0);
    bus.branch_taken_EXB  = (bt != 0);
    bus.branch_target_EXB = tgt;
    e.name = name;
    e.f    = ef;
    e.pc   = epc;
    q.push_back(e);
  endtask

  task automatic idle(input string name, input logic [11:0] ef, input logic [63:0] epc);
    cyc(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, ef, epc);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [11:0] af;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        af = {bus.stall_IFP, bus.stall_IFR, bus.stall_IDC, bus.stall_IDR, bus.stall_EXA,
              bus.bubble_EXA, bus.flush_IFR, bus.flush_IDC, bus.flush_IDR, bus.flush_EXA,
              bus.redirect_valid_IFP, bus.md_timeout};
        vectors++;
        if ({af, bus.redirect_pc_IFP} !== {e.f, e.pc}) begin
          miscompares++;
          $display("FAIL %s: got flags=%b pc=%h, want flags=%b pc=%h",
                   e.name, af, bus.redirect_pc_IFP, e.f, e.pc);
        end
      end
    end
  end

  initial begin
    {bus.rd_EXA, bus.mem_read_EXA, bus.rs1_IDR, bus.rs1_used_IDR, bus.rs2_IDR,
     bus.rs2_used_IDR, bus.md_req_EXA, bus.md_done, bus.branch_taken_EXB} = '0;
    bus.branch_target_EXB = Z;
    cyc("rst_lu_br", 1, 5, 1, 5, 1, 0, 0, 0, 0, 1, T1, NONE, Z);
    cyc("rst_md", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, Z, NONE, Z);
    idle("post_rst", NONE, Z);
    cyc("lu_rs1", 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, Z, LU, Z);
    idle("lu_once", NONE, Z);
    cyc("lu_x0", 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, Z, NONE, Z);
    cyc("lu_rs2", 0, 7, 1, 3, 1, 7, 1, 0, 0, 0, Z, LU, Z);
    cyc("rs2_unused", 0, 7, 1, 3, 1, 7, 0, 0, 0, 0, Z, NONE, Z);
    cyc("no_load", 0, 7, 0, 7, 1, 7, 1, 0, 0, 0, Z, NONE, Z);
    cyc("br", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, T1, BR, Z);
    idle("redir", RED, T1);
    idle("redir_once", NONE, T1);
    cyc("br_over_lu", 0, 5, 1, 5, 1, 0, 0, 0, 0, 1, T2, BR, T1);
    idle("redir2", RED, T2);
    cyc("md_req", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, Z, NONE, T2);
    for (int i = 1; i <= 5; i++)
      if (i == 3) cyc("md_wait_lu", 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, Z, MDS, T2);
      else idle("md_wait", MDS, T2);
    cyc("md_done", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, Z, NONE, T2);
    cyc("md_back_lu", 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, Z, LU, T2);
    cyc("md_req_done", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, Z, NONE, T2);
    idle("no_wait", NONE, T2);
    cyc("md_req_to", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, Z, NONE, T2);
    for (int i = 1; i <= 7; i++) idle("to_wait", MDS, T2);
    idle("timeout", TO, T2);
    idle("to_run", NONE, T2);
    cyc("md_req_br", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, Z, NONE, T2);
    idle("br_wait1", MDS, T2);
    idle("br_wait2", MDS, T2);
    cyc("br_in_wait", 0, 5, 1, 5, 1, 0, 0, 0, 0, 1, T3, BR, T2);
    idle("redir3", RED, T3);
    idle("run_after_br", NONE, T3);
    cyc("req_with_br", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, T1, BR, T3);
    idle("redir4", RED, T1);
    idle("no_wait_br", NONE, T1);
    cyc("md_req_rst", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, Z, NONE, T1);
    idle("rst_wait1", MDS, T1);
    idle("rst_wait2", MDS, T1);
    cyc("rst_in_wait", 1, 5, 1, 5, 1, 0, 0, 0, 0, 0, Z, NONE, T1);
    for (int i = 1; i <= 8; i++) idle("post_rst_wait", NONE, Z);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
